// File: rtl/lives_hud_controller.sv
// rtl/lives_hud_controller.sv - lives counter, hit blink/invulnerability FSM and heart-slot pixel gate
// Optional EXTRA_LIFE_EN: bonus pulse adds a life in ALIVE/INVULN, saturating at MAX_LIVES.
module lives_hud_controller #(
    parameter int MAX_LIVES     = 3,
    parameter int HEART_W       = 20,
    parameter int BLINK_FRAMES  = 8,
    parameter int BLINK_PHASES  = 6,
    parameter int INVULN_FRAMES = 60
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           startOfFrame,
    input  logic                           hit,
    input  logic                           newGame,
    input  logic                           bonus,
    input  logic [10:0]                    offsetX,
    input  logic                           insideRectIn,
    output logic                           insideRectOut,
    output logic [$clog2(MAX_LIVES+1)-1:0] livesLeft,
    output logic                           invulnerable,
    output logic                           gameOver
);
    localparam int LW   = $clog2(MAX_LIVES + 1);
    localparam int FMAX = (INVULN_FRAMES > BLINK_FRAMES) ? INVULN_FRAMES : BLINK_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);
    localparam int PW   = $clog2(BLINK_PHASES + 1);

    typedef enum logic [1:0] {ALIVE, BLINK, INVULN, GAME_OVER} state_t;

    state_t          state;
    logic [FW-1:0]   frame_cnt;
    logic [PW-1:0]   phase_cnt;
    logic [LW-1:0]   lost_slot;
    logic [LW-1:0]   lives_dec;
    logic [LW-1:0]   lives_inc;
    logic [LW-1:0]   slot;
    logic            in_range;
    logic            bonus_ok;

`ifdef EXTRA_LIFE_EN
    assign bonus_ok = bonus;
`else
    logic unused_bonus;
    assign unused_bonus = bonus;
    assign bonus_ok     = 1'b0;
`endif

    assign lives_dec = (livesLeft == '0) ? '0 : livesLeft - 1'b1;
    assign lives_inc = (livesLeft == LW'(MAX_LIVES)) ? livesLeft : livesLeft + 1'b1;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= ALIVE;
            livesLeft    <= LW'(MAX_LIVES);
            frame_cnt    <= '0;
            phase_cnt    <= '0;
            lost_slot    <= '0;
            invulnerable <= 1'b0;
            gameOver     <= 1'b0;
        end else if (newGame) begin
            state        <= ALIVE;
            livesLeft    <= LW'(MAX_LIVES);
            frame_cnt    <= '0;
            phase_cnt    <= '0;
            invulnerable <= 1'b0;
            gameOver     <= 1'b0;
        end else begin
            case (state)
                ALIVE: begin
                    // The hit frame itself is not counted: counters restart from zero here.
                    if (hit) begin
                        livesLeft    <= lives_dec;
                        lost_slot    <= lives_dec;
                        frame_cnt    <= '0;
                        phase_cnt    <= '0;
                        invulnerable <= 1'b1;
                        state        <= BLINK;
                    end else if (bonus_ok) begin
                        livesLeft <= lives_inc;
                    end
                end
                BLINK: begin
                    if (startOfFrame) begin
                        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                            frame_cnt <= '0;
                            if (phase_cnt == PW'(BLINK_PHASES - 1)) begin
                                phase_cnt <= '0;
                                if (livesLeft == '0) begin
                                    state        <= GAME_OVER;
                                    gameOver     <= 1'b1;
                                    invulnerable <= 1'b0;
                                end else begin
                                    state <= INVULN;
                                end
                            end else begin
                                phase_cnt <= phase_cnt + 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                INVULN: begin
                    if (bonus_ok)
                        livesLeft <= lives_inc;
                    if (startOfFrame) begin
                        if (frame_cnt == FW'(INVULN_FRAMES - 1)) begin
                            frame_cnt    <= '0;
                            invulnerable <= 1'b0;
                            state        <= ALIVE;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                GAME_OVER: begin
                    gameOver <= 1'b1;
                end
                default: state <= ALIVE;
            endcase
        end
    end

    // Slot index from a chain of threshold compares instead of a divider.
    always_comb begin
        slot = '0;
        for (int i = 1; i < MAX_LIVES; i++) begin
            if (offsetX >= 11'(i * HEART_W))
                slot = LW'(i);
        end
        in_range = (offsetX < 11'(MAX_LIVES * HEART_W));
    end

    assign insideRectOut = insideRectIn && in_range &&
                           ((slot < livesLeft) ||
                            (state == BLINK && slot == lost_slot && !phase_cnt[0]));
endmodule
